ifetch: RTL and testbench

Instruction fetch stage of the ARM32 pipeline, directly upstream of the instruction decoder. Owns the fetch PC, issues word reads to instruction memory over a request/response interface with one outstanding access, and buffers returned words in a small queue. Presents each instruction word and its address to the decoder with a valid/ready handshake. Redirects the PC on a taken branch, discarding all stale words.

---
 rtl/ifetch.sv | 153 +++++++++++++++
 tb/tb_ifetch.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch: owns the fetch PC, keeps one read in flight, and queues words for the decoder.
// Memory read data is registered into the queue and appears on ir one cycle later; requests stall while the queue has no room.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] QD = CW'(QDEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    state_t        w_ready_state;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_req_pc;
    logic [31:0]   r_q_pc   [QDEPTH];
    logic [31:0]   r_q_word [QDEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          w_accept;
    logic          w_rsp;
    logic          w_push;
    logic          w_pop;

    assign w_accept  = imem_req && imem_ready;
    // A response only counts while an access is actually in flight.
    assign w_rsp     = imem_rvalid && ((r_state == S_WAIT) || (r_state == S_DRAIN));
    assign w_push    = w_rsp && (r_state == S_WAIT) && !redirect;
    assign w_pop     = ir_valid && ir_ready && !redirect;

    assign imem_addr = r_fetch_pc;
    assign ir_valid  = (r_count != '0);
    assign ir        = r_q_word[r_head];
    assign ir_pc     = r_q_pc[r_head];

    always_comb begin
        w_count_nxt = r_count;
        if (redirect) begin
            w_count_nxt = '0;
        end else begin
            w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        imem_req      = (r_state == S_REQ) && !rst;
        // Request again only if the response slot is still free after this cycle.
        w_ready_state = (w_count_nxt < QD) ? S_REQ : S_IDLE;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = w_ready_state;
            end
            S_REQ: begin
                if (w_accept) begin
                    w_state_nxt = redirect ? S_DRAIN : S_WAIT;
                end else begin
                    w_state_nxt = w_ready_state;
                end
            end
            S_WAIT: begin
                if (w_rsp) begin
                    w_state_nxt = w_ready_state;
                end else if (redirect) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_DRAIN: begin
                if (w_rsp) begin
                    w_state_nxt = w_ready_state;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_REQ;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_accept) begin
                r_req_pc <= r_fetch_pc;
            end
            if (redirect) begin
                r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            end else if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (redirect) begin
                r_head <= '0;
                r_tail <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + 1'b1;
                end
                if (w_pop) begin
                    r_head <= r_head + 1'b1;
                end
            end
        end
    end

    // Storage is cleared on reset so ir/ir_pc read zero until the first word lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_pc[i]   <= '0;
                r_q_word[i] <= '0;
            end
        end else if (w_push) begin
            r_q_pc[r_tail]   <= r_req_pc;
            r_q_word[r_tail] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a cycle table for streaming and back-pressure, then hand sequences for redirect, reset and PC wrap.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst2 = 1'b1;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        ir_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        imem_req, ir_valid;
    logic [31:0] imem_addr, ir, ir_pc;
    logic        imem_req_b, ir_valid_b;
    logic [31:0] imem_addr_b, ir_b, ir_pc_b;

    logic        sel2 = 1'b0;
    int          n_total = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    ifetch #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    ifetch #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst2),
        .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ir(ir_b), .ir_pc(ir_pc_b), .ir_valid(ir_valid_b), .ir_ready(ir_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    typedef struct {
        logic        r;
        logic        rdy;
        logic        rv;
        logic [31:0] rda;
        logic        irr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] enc(input logic [31:0] a);
        return a ^ 32'hE3A0_5000;
    endfunction

    function automatic void add(input logic r, input logic rdy, input logic rv, input logic [31:0] rda,
                                input logic irr, input logic e_req, input logic [31:0] e_addr,
                                input logic e_val, input logic [31:0] e_pc);
        vec_t v;
        v.r = r; v.rdy = rdy; v.rv = rv; v.rda = rda; v.irr = irr;
        v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_pc = e_pc;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic rdy, input logic rv, input logic [31:0] rda,
                       input logic irr, input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        if (sel2) rst2 = r;
        else rst = r;
        imem_ready  = rdy;
        imem_rvalid = rv;
        imem_rdata  = rv ? enc(rda) : 32'hDEAD_BEEF;
        ir_ready    = irr;
        redirect    = redir;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic expect_o(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_val, input logic [31:0] e_pc);
        logic        a_req, a_val;
        logic [31:0] a_addr, a_ir, a_pc;
        a_req  = sel2 ? imem_req_b  : imem_req;
        a_val  = sel2 ? ir_valid_b  : ir_valid;
        a_addr = sel2 ? imem_addr_b : imem_addr;
        a_ir   = sel2 ? ir_b        : ir;
        a_pc   = sel2 ? ir_pc_b     : ir_pc;
        chk({tag, ".imem_req"}, {31'b0, a_req}, {31'b0, e_req});
        if (e_req) chk({tag, ".imem_addr"}, a_addr, e_addr);
        chk({tag, ".ir_valid"}, {31'b0, a_val}, {31'b0, e_val});
        if (e_val) begin
            chk({tag, ".ir_pc"}, a_pc, e_pc);
            chk({tag, ".ir"}, a_ir, enc(e_pc));
        end
    endtask

    task automatic expect_rst(input string tag, input logic [31:0] rpc);
        chk({tag, ".imem_req"}, {31'b0, sel2 ? imem_req_b : imem_req}, 32'd0);
        chk({tag, ".imem_addr"}, sel2 ? imem_addr_b : imem_addr, rpc);
        chk({tag, ".ir_valid"}, {31'b0, sel2 ? ir_valid_b : ir_valid}, 32'd0);
        chk({tag, ".ir"}, sel2 ? ir_b : ir, 32'd0);
        chk({tag, ".ir_pc"}, sel2 ? ir_pc_b : ir_pc, 32'd0);
    endtask

    initial begin
        // r  rdy rv  rdata_addr   irr | req addr          val pc
        add(1, 1, 0, 32'h0,  1,   0, 32'h0,  0, 32'h0);
        add(0, 1, 0, 32'h0,  1,   1, 32'h0,  0, 32'h0);
        add(0, 1, 1, 32'h0,  1,   0, 32'h0,  0, 32'h0);
        add(0, 1, 0, 32'h0,  1,   1, 32'h4,  1, 32'h0);
        add(0, 1, 1, 32'h4,  1,   0, 32'h0,  0, 32'h0);
        add(0, 1, 0, 32'h0,  1,   1, 32'h8,  1, 32'h4);
        add(0, 1, 1, 32'h8,  1,   0, 32'h0,  0, 32'h0);
        add(0, 1, 0, 32'h0,  0,   1, 32'hC,  1, 32'h8);
        add(0, 1, 1, 32'hC,  0,   0, 32'h0,  1, 32'h8);
        for (int k = 0; k < 8; k++) add(0, 1, 0, 32'h0, 0, 0, 32'h0, 1, 32'h8);
        add(0, 1, 0, 32'h0,  1,   0, 32'h0,  1, 32'h8);
        add(0, 1, 0, 32'h0,  1,   1, 32'h10, 1, 32'hC);
        add(0, 1, 1, 32'h10, 1,   0, 32'h0,  0, 32'h0);
        add(0, 0, 0, 32'h0,  1,   1, 32'h14, 1, 32'h10);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].r, tbl[i].rdy, tbl[i].rv, tbl[i].rda, tbl[i].irr, 1'b0, 32'h0);
            if (tbl[i].r) expect_rst($sformatf("A%0d", i), 32'h0);
            else expect_o($sformatf("A%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_val, tbl[i].e_pc);
        end

        // Redirect while an access is outstanding, then again while draining it.
        cyc(1, 1, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 1, 0, 0);                        expect_o("B0", 1, 32'h0, 0, 0);
        cyc(0, 1, 1, 32'h0, 1, 0, 0);                    expect_o("B1", 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 0, 0);                        expect_o("B2", 1, 32'h4, 1, 32'h0);
        cyc(0, 1, 1, 32'h4, 1, 0, 0);                    expect_o("B3", 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);                        expect_o("B4", 1, 32'h8, 1, 32'h4);
        cyc(0, 1, 0, 0, 0, 1, 32'h303);                  expect_o("B5", 0, 0, 1, 32'h4);
        cyc(0, 1, 0, 0, 1, 1, 32'h100);                  expect_o("B6", 0, 0, 0, 0);
        cyc(0, 1, 1, 32'h8, 1, 0, 0);                    expect_o("B7", 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 0, 0);                        expect_o("B8", 1, 32'h100, 0, 0);
        cyc(0, 1, 1, 32'h100, 1, 0, 0);                  expect_o("B9", 0, 0, 0, 0);
        // Redirect together with a returning word and an attempted pop.
        cyc(0, 1, 0, 0, 0, 0, 0);                        expect_o("B10", 1, 32'h104, 1, 32'h100);
        cyc(0, 1, 1, 32'h104, 1, 1, 32'h200);            expect_o("B11", 0, 0, 1, 32'h100);
        cyc(0, 1, 0, 0, 1, 0, 0);                        expect_o("B12", 1, 32'h200, 0, 0);
        cyc(0, 1, 1, 32'h200, 1, 0, 0);                  expect_o("B13", 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);                        expect_o("B14", 1, 32'h204, 1, 32'h200);
        for (int k = 15; k < 19; k++) begin
            cyc(0, 0, 0, 0, 1, 0, 0);                    expect_o($sformatf("B%0d", k), 1, 32'h204, 0, 0);
        end
        cyc(0, 1, 0, 0, 1, 0, 0);                        expect_o("B19", 1, 32'h204, 0, 0);
        // Reset while the access to 0x204 is in flight; its late response must vanish.
        cyc(1, 1, 0, 0, 1, 0, 0);                        expect_rst("B20", 32'h0);
        cyc(0, 1, 1, 32'h204, 1, 0, 0);                  expect_o("B21", 1, 32'h0, 0, 0);
        cyc(0, 0, 1, 32'h0, 1, 0, 0);                    expect_o("B22", 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);                        expect_o("B23", 1, 32'h4, 1, 32'h0);
        cyc(0, 0, 0, 0, 1, 0, 0);                        expect_o("B24", 1, 32'h4, 0, 0);

        // Second instance: PC wrap from the top of memory and four-deep buffering.
        cyc(1, 0, 0, 0, 1, 0, 0);
        sel2 = 1'b1;
        cyc(1, 1, 0, 0, 1, 0, 0);                        expect_rst("Cr", 32'hFFFF_FFF8);
        cyc(0, 1, 0, 0, 1, 0, 0);                        expect_o("C0", 1, 32'hFFFF_FFF8, 0, 0);
        cyc(0, 1, 1, 32'hFFFF_FFF8, 1, 0, 0);            expect_o("C1", 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 0, 0);                        expect_o("C2", 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8);
        cyc(0, 1, 1, 32'hFFFF_FFFC, 1, 0, 0);            expect_o("C3", 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 0, 0);                        expect_o("C4", 1, 32'h0, 1, 32'hFFFF_FFFC);
        cyc(0, 1, 1, 32'h0, 1, 0, 0);                    expect_o("C5", 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);                        expect_o("C6", 1, 32'h4, 1, 32'h0);
        cyc(0, 1, 1, 32'h4, 0, 0, 0);                    expect_o("C7", 0, 0, 1, 32'h0);
        cyc(0, 1, 0, 0, 0, 0, 0);                        expect_o("C8", 1, 32'h8, 1, 32'h0);
        cyc(0, 1, 1, 32'h8, 0, 0, 0);                    expect_o("C9", 0, 0, 1, 32'h0);
        cyc(0, 1, 0, 0, 0, 0, 0);                        expect_o("C10", 1, 32'hC, 1, 32'h0);
        cyc(0, 1, 1, 32'hC, 0, 0, 0);                    expect_o("C11", 0, 0, 1, 32'h0);
        cyc(0, 1, 0, 0, 0, 0, 0);                        expect_o("C12", 0, 0, 1, 32'h0);
        cyc(0, 1, 0, 0, 0, 0, 0);                        expect_o("C13", 0, 0, 1, 32'h0);
        cyc(0, 0, 0, 0, 1, 0, 0);                        expect_o("C14", 0, 0, 1, 32'h0);
        cyc(0, 0, 0, 0, 1, 0, 0);                        expect_o("C15", 1, 32'h10, 1, 32'h4);
        cyc(0, 0, 0, 0, 1, 0, 0);                        expect_o("C16", 1, 32'h10, 1, 32'h8);
        cyc(0, 0, 0, 0, 1, 0, 0);                        expect_o("C17", 1, 32'h10, 1, 32'hC);
        cyc(0, 0, 0, 0, 1, 0, 0);                        expect_o("C18", 1, 32'h10, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
